// File: rtl/room_temp_model.sv
// room_temp_model: synthesisable thermal plant for closed-loop air-conditioning demos.
// Temperature moves by at most one degree per thermal step. Heating or cooling
// commands are sampled only at step boundaries. A load input forces the temperature
// and restarts the step period.
module room_temp_model #(
    parameter int unsigned STEP_CYCLES = 4,   // clock cycles per thermal step (>= 1)
    parameter int unsigned INIT_TEMP   = 20,  // temperature loaded on reset
    parameter int unsigned AMBIENT     = 16   // drift target with no active command
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    input  logic       load,
    input  logic [4:0] load_temp,
    output logic [4:0] temp,
    output logic       step,
    output logic [1:0] mode,
    output logic       fault
);

    localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);
    localparam logic [4:0] TempInit = 5'(INIT_TEMP);
    localparam logic [4:0] TempAmb  = 5'(AMBIENT);
    localparam logic [4:0] TempMax  = 5'd31;
    localparam logic [4:0] TempMin  = 5'd0;

    typedef enum logic [1:0] {
        ModeDrift = 2'd0,
        ModeCool  = 2'd1,
        ModeHeat  = 2'd2,
        ModeFault = 2'd3
    } mode_e;

    logic [CntW-1:0] r_cnt;
    logic [4:0]      r_temp;
    logic            r_step;
    mode_e           r_mode;
    logic            r_fault;

    logic            w_step_edge;
    logic [CntW-1:0] w_cnt_next;
    logic [4:0]      w_temp_up;
    logic [4:0]      w_temp_dn;
    logic [4:0]      w_temp_next;
    mode_e           w_mode_next;
    logic            w_conflict;

    // The prescaler's last count marks a step edge. With STEP_CYCLES=1 every edge is a step edge.
    assign w_step_edge = (r_cnt == CntLast);
    assign w_cnt_next  = w_step_edge ? '0 : r_cnt + 1'b1;

    // Saturating +/-1 candidates. The plant never wraps.
    assign w_temp_up  = (r_temp == TempMax) ? TempMax : r_temp + 5'd1;
    assign w_temp_dn  = (r_temp == TempMin) ? TempMin : r_temp - 5'd1;
    assign w_conflict = heating & cooling;

    // Decode the command sampled at a step edge into the new temperature and mode.
    always_comb begin
        w_temp_next = r_temp;
        w_mode_next = ModeDrift;
        unique case ({heating, cooling})
            2'b10: begin
                w_temp_next = w_temp_up;
                w_mode_next = ModeHeat;
            end
            2'b01: begin
                w_temp_next = w_temp_dn;
                w_mode_next = ModeCool;
            end
            2'b11: begin
                // Conflicting commands: hold temperature and report the fault.
                w_temp_next = r_temp;
                w_mode_next = ModeFault;
            end
            default: begin
                // Drift one degree toward ambient and hold once there.
                if (r_temp > TempAmb) begin
                    w_temp_next = w_temp_dn;
                end else if (r_temp < TempAmb) begin
                    w_temp_next = w_temp_up;
                end else begin
                    w_temp_next = r_temp;
                end
                w_mode_next = ModeDrift;
            end
        endcase
    end

    // Plant state. Priority: reset, then load (which discards a coincident step), then step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_temp  <= TempInit;
            r_step  <= 1'b0;
            r_mode  <= ModeDrift;
            r_fault <= 1'b0;
        end else if (load) begin
            r_cnt  <= '0;
            r_temp <= load_temp;
            r_step <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_step <= w_step_edge;
            if (w_step_edge) begin
                r_temp  <= w_temp_next;
                r_mode  <= w_mode_next;
                r_fault <= r_fault | w_conflict;
            end
        end
    end

    assign temp  = r_temp;
    assign step  = r_step;
    assign mode  = r_mode;
    assign fault = r_fault;

endmodule

// File: tb/tb_room_temp_model.sv
// tb_room_temp_model: scoreboard bench for room_temp_model with default parameters.
module tb_room_temp_model;

    localparam int unsigned StepCycles = 4;
    localparam int unsigned InitTemp   = 20;
    localparam int unsigned Ambient    = 16;

    typedef struct packed {
        logic [4:0] temp;
        logic       step;
        logic [1:0] mode;
        logic       fault;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       heating = 1'b0;
    logic       cooling = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_temp = 5'd0;
    logic [4:0] temp;
    logic       step;
    logic [1:0] mode;
    logic       fault;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_cnt;

    // Reference plant state
    int   m_cnt;
    int   m_temp;
    int   m_step;
    int   m_mode;
    int   m_fault;

    room_temp_model #(
        .STEP_CYCLES(StepCycles),
        .INIT_TEMP  (InitTemp),
        .AMBIENT    (Ambient)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .heating  (heating),
        .cooling  (cooling),
        .load     (load),
        .load_temp(load_temp),
        .temp     (temp),
        .step     (step),
        .mode     (mode),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the reference plant by one rising edge
    task automatic model_edge(input logic r, input logic h, input logic c, input logic ld,
                              input logic [4:0] lt);
        if (r) begin
            m_cnt = 0; m_temp = InitTemp; m_step = 0; m_mode = 0; m_fault = 0;
        end else if (ld) begin
            m_cnt = 0; m_temp = int'(lt); m_step = 0;
        end else if (m_cnt == StepCycles - 1) begin
            m_cnt  = 0;
            m_step = 1;
            if (h && !c) begin
                m_temp = (m_temp >= 31) ? 31 : m_temp + 1; m_mode = 2;
            end else if (!h && c) begin
                m_temp = (m_temp <= 0) ? 0 : m_temp - 1; m_mode = 1;
            end else if (h && c) begin
                m_mode = 3; m_fault = 1;
            end else begin
                if (m_temp > Ambient) m_temp = m_temp - 1;
                else if (m_temp < Ambient) m_temp = m_temp + 1;
                m_mode = 0;
            end
        end else begin
            m_cnt  = m_cnt + 1;
            m_step = 0;
        end
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge
    task automatic tick(input logic r, input logic h, input logic c, input logic ld,
                        input logic [4:0] lt);
        exp_t e;
        rst = r; heating = h; cooling = c; load = ld; load_temp = lt;
        model_edge(r, h, c, ld, lt);
        e.temp  = 5'(m_temp);
        e.step  = m_step[0];
        e.mode  = 2'(m_mode);
        e.fault = m_fault[0];
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("temp",  int'(temp),  int'(e.temp));
        check("step",  int'(step),  int'(e.step));
        check("mode",  int'(mode),  int'(e.mode));
        check("fault", int'(fault), int'(e.fault));
        if (step === 1'b1) step_cnt++;
    endtask

    initial begin
        m_cnt = 0; m_temp = InitTemp; m_step = 0; m_mode = 0; m_fault = 0;

        // 1: heating from reset
        tick(1, 0, 0, 0, 5'd0);
        check("t1_reset_temp", int'(temp), 20);
        check("t1_reset_step", int'(step), 0);
        step_cnt = 0;
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 5'd0);
        check("t1_no_step_yet", int'(step), 0);
        tick(0, 1, 0, 0, 5'd0);
        check("t1_first_step", int'(temp), 21);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 5'd0);
        check("t1_temp22", int'(temp), 22);
        check("t1_mode_heat", int'(mode), 2);
        check("t1_step_count", step_cnt, 2);

        // 2: high-end saturation
        tick(0, 0, 0, 1, 5'd30);
        check("t2_load30", int'(temp), 30);
        for (int i = 0; i < 12; i++) tick(0, 1, 0, 0, 5'd0);
        check("t2_sat31", int'(temp), 31);

        // 3: low-end saturation
        tick(0, 0, 0, 1, 5'd1);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 5'd0);
        check("t3_sat0", int'(temp), 0);
        check("t3_mode_cool", int'(mode), 1);

        // 4: drift toward ambient from above and below
        tick(1, 0, 0, 0, 5'd0);
        for (int i = 0; i < 24; i++) tick(0, 0, 0, 0, 5'd0);
        check("t4_hold16", int'(temp), 16);
        tick(0, 0, 0, 1, 5'd10);
        for (int i = 0; i < 28; i++) tick(0, 0, 0, 0, 5'd0);
        check("t4_rise16", int'(temp), 16);
        check("t4_mode_drift", int'(mode), 0);

        // 5: conflict sets a sticky fault
        tick(1, 0, 0, 0, 5'd0);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 5'd0);
        check("t5_temp_hold", int'(temp), 20);
        check("t5_mode_fault", int'(mode), 3);
        check("t5_fault_set", int'(fault), 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 5'd0);
        check("t5_mode_drift", int'(mode), 0);
        check("t5_fault_sticky", int'(fault), 1);

        // 6: load mid-period restarts the step, reset mid-step clears everything
        tick(1, 0, 0, 0, 5'd0);
        tick(0, 1, 0, 0, 5'd0);
        tick(0, 1, 0, 0, 5'd0);
        tick(0, 1, 0, 1, 5'd25);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 5'd0);
        check("t6_no_early_step", int'(step), 0);
        tick(0, 1, 0, 0, 5'd0);
        check("t6_step_after_load", int'(step), 1);
        check("t6_temp26", int'(temp), 26);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 0, 5'd0);
        check("t6_temp27", int'(temp), 27);
        tick(1, 1, 0, 0, 5'd0);
        check("t6_rst_temp", int'(temp), 20);
        check("t6_rst_fault", int'(fault), 0);
        check("t6_rst_step", int'(step), 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 5'd0);
        check("t6_after_rst", int'(temp), 21);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
